// File: rtl/ifm_out_fsm.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ifm_out_fsm
// Description : Receive-path egress stage of the 10G Ethernet core. Pairs the
//               status byte of each frame (info FIFO) with that frame's beats
//               (data FIFO). Good frames are replayed onto the S2MM AXI-Stream
//               master; errored frames are drained silently. Reports the byte
//               length of each forwarded frame plus good/bad frame counters.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   s2mm_clk          in   clock, all logic on rising edge
//   s2mm_resetn       in   asynchronous active-low reset
//   data_fifo_rdata   in   FWFT head: [63:0] data, [71:64] keep, [72] last
//   data_fifo_empty   in   data FIFO empty
//   data_fifo_rden    out  pop data head this cycle (combinational)
//   info_fifo_rdata   in   FWFT head status, bit0 = frame good
//   info_fifo_empty   in   info FIFO empty
//   info_fifo_rden    out  pop info head this cycle (combinational)
//   s2mm_t*           out  registered AXI-Stream master (tdata/tkeep/tlast/tvalid)
//   s2mm_tready       in   downstream ready
//   frame_len         out  byte length of the last forwarded good frame
//   frame_len_valid   out  one-cycle pulse when frame_len updates
//   good_frames       out  wrapping count of forwarded frames
//   bad_frames        out  wrapping count of dropped frames
//   ifm_out_fsm_dbg   out  {2'b00, state}
// ============================================================================
module ifm_out_fsm (
  input  logic        s2mm_clk,
  input  logic        s2mm_resetn,
  input  logic [72:0] data_fifo_rdata,
  input  logic        data_fifo_empty,
  output logic        data_fifo_rden,
  input  logic [7:0]  info_fifo_rdata,
  input  logic        info_fifo_empty,
  output logic        info_fifo_rden,
  output logic [63:0] s2mm_tdata,
  output logic [7:0]  s2mm_tkeep,
  output logic        s2mm_tlast,
  output logic        s2mm_tvalid,
  input  logic        s2mm_tready,
  output logic [15:0] frame_len,
  output logic        frame_len_valid,
  output logic [31:0] good_frames,
  output logic [31:0] bad_frames,
  output logic [3:0]  ifm_out_fsm_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PASS = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_popped_last;
  logic [15:0] r_len_acc;

  logic        w_load;
  logic        w_pass_entry;
  logic        w_pass_done;
  logic        w_drop_last;
  logic [3:0]  w_beat_bytes;
  logic [16:0] w_len_sum;
  logic [15:0] w_len_next;
  logic [1:0]  w_state_bits;
  logic        w_unused_info;

  // Status bits [7:1] carry no meaning for this stage.
  assign w_unused_info = ^info_fifo_rdata[7:1];

  function automatic logic [3:0] f_popcount(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'd0, v[i]};
    end
    return cnt;
  endfunction

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge s2mm_clk or negedge s2mm_resetn) begin
    if (!s2mm_resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and FIFO pop strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    info_fifo_rden = 1'b0;
    data_fifo_rden = 1'b0;
    w_load         = 1'b0;
    w_pass_entry   = 1'b0;
    w_pass_done    = 1'b0;
    w_drop_last    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!info_fifo_empty) begin
          info_fifo_rden = 1'b1;
          if (info_fifo_rdata[0]) begin
            w_state_next = S_PASS;
            w_pass_entry = 1'b1;
          end else begin
            w_state_next = S_DROP;
          end
        end
      end
      S_PASS: begin
        // Single-stage skid-less output: refill only when the register is
        // empty or being consumed, and never past the frame's last beat.
        w_load         = ~r_popped_last & ~data_fifo_empty &
                         (~s2mm_tvalid | s2mm_tready);
        data_fifo_rden = w_load;
        if (s2mm_tvalid & s2mm_tready & s2mm_tlast) begin
          w_pass_done  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_DROP: begin
        data_fifo_rden = ~data_fifo_empty;
        if (~data_fifo_empty & data_fifo_rdata[72]) begin
          w_drop_last  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Bytes contributed by the beat being loaded: full word unless it is the
  // last beat, where keep tells how many lanes are valid.
  assign w_beat_bytes = data_fifo_rdata[72] ? f_popcount(data_fifo_rdata[71:64]) : 4'd8;
  assign w_len_sum    = {1'b0, r_len_acc} + {13'd0, w_beat_bytes};
  assign w_len_next   = w_len_sum[16] ? 16'hFFFF : w_len_sum[15:0];

  // --------------------------------------------------------------------------
  // Output register, length accumulator and statistics
  // --------------------------------------------------------------------------
  always_ff @(posedge s2mm_clk or negedge s2mm_resetn) begin
    if (!s2mm_resetn) begin
      r_popped_last   <= 1'b0;
      r_len_acc       <= 16'd0;
      s2mm_tdata      <= 64'd0;
      s2mm_tkeep      <= 8'd0;
      s2mm_tlast      <= 1'b0;
      s2mm_tvalid     <= 1'b0;
      frame_len       <= 16'd0;
      frame_len_valid <= 1'b0;
      good_frames     <= 32'd0;
      bad_frames      <= 32'd0;
    end else begin
      frame_len_valid <= 1'b0;

      if (w_pass_entry) begin
        r_popped_last <= 1'b0;
        r_len_acc     <= 16'd0;
      end

      if (w_load) begin
        s2mm_tdata  <= data_fifo_rdata[63:0];
        s2mm_tkeep  <= data_fifo_rdata[71:64];
        s2mm_tlast  <= data_fifo_rdata[72];
        s2mm_tvalid <= 1'b1;
        r_len_acc   <= w_len_next;
        if (data_fifo_rdata[72]) begin
          r_popped_last <= 1'b1;
        end
      end else if (s2mm_tready) begin
        s2mm_tvalid <= 1'b0;
      end

      // The last beat was loaded at least one cycle earlier, so the
      // accumulator already holds the full frame length here.
      if (w_pass_done) begin
        frame_len       <= r_len_acc;
        frame_len_valid <= 1'b1;
        good_frames     <= good_frames + 32'd1;
      end

      if (w_drop_last) begin
        bad_frames <= bad_frames + 32'd1;
      end
    end
  end

  assign w_state_bits    = r_state;
  assign ifm_out_fsm_dbg = {2'b00, w_state_bits};

endmodule
`default_nettype wire

// File: tb/tb_ifm_out_fsm.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ifm_out_fsm
// Description : Self-checking bench for ifm_out_fsm with FWFT FIFO models and
//               an expected-beat / expected-length scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifm_out_fsm;

  logic        s2mm_clk;
  logic        s2mm_resetn;
  logic [72:0] data_fifo_rdata;
  logic        data_fifo_empty;
  logic        data_fifo_rden;
  logic [7:0]  info_fifo_rdata;
  logic        info_fifo_empty;
  logic        info_fifo_rden;
  logic [63:0] s2mm_tdata;
  logic [7:0]  s2mm_tkeep;
  logic        s2mm_tlast;
  logic        s2mm_tvalid;
  logic        s2mm_tready;
  logic [15:0] frame_len;
  logic        frame_len_valid;
  logic [31:0] good_frames;
  logic [31:0] bad_frames;
  logic [3:0]  ifm_out_fsm_dbg;

  ifm_out_fsm dut (
    .s2mm_clk        (s2mm_clk),
    .s2mm_resetn     (s2mm_resetn),
    .data_fifo_rdata (data_fifo_rdata),
    .data_fifo_empty (data_fifo_empty),
    .data_fifo_rden  (data_fifo_rden),
    .info_fifo_rdata (info_fifo_rdata),
    .info_fifo_empty (info_fifo_empty),
    .info_fifo_rden  (info_fifo_rden),
    .s2mm_tdata      (s2mm_tdata),
    .s2mm_tkeep      (s2mm_tkeep),
    .s2mm_tlast      (s2mm_tlast),
    .s2mm_tvalid     (s2mm_tvalid),
    .s2mm_tready     (s2mm_tready),
    .frame_len       (frame_len),
    .frame_len_valid (frame_len_valid),
    .good_frames     (good_frames),
    .bad_frames      (bad_frames),
    .ifm_out_fsm_dbg (ifm_out_fsm_dbg)
  );

  initial s2mm_clk = 1'b0;
  always #5 s2mm_clk = ~s2mm_clk;

  // FIFO models and scoreboard
  logic [72:0] dq[$];
  logic [7:0]  iq[$];
  logic [72:0] exp_q[$];
  logic [15:0] len_q[$];

  int total = 0;
  int bad   = 0;
  int cyc = 0;
  int pop_cnt, hs_cnt, len_pulses, valid_cnt, gap_checks;
  int info_pop_cyc = 0;
  int last_end_cyc = 0;
  int ready_mode = 0;
  int rdy_idx = 0;
  bit gap_armed = 0, gap_check = 0, first_pending = 0, cur_good = 0;
  bit held = 0, prev_tvalid = 0;
  logic [72:0] held_val;

  function automatic logic [15:0] popcnt8(input logic [7:0] v);
    logic [15:0] c;
    c = 16'd0;
    for (int i = 0; i < 8; i++) c = c + {15'd0, v[i]};
    return c;
  endfunction

  task automatic update_heads();
    data_fifo_empty = (dq.size() == 0);
    data_fifo_rdata = (dq.size() == 0) ? 73'd0 : dq[0];
    info_fifo_empty = (iq.size() == 0);
    info_fifo_rdata = (iq.size() == 0) ? 8'd0 : iq[0];
  endtask

  task automatic push_frame(input logic [7:0] info, input int nb, input logic [7:0] last_keep);
    logic [72:0] w;
    logic [63:0] d;
    logic [15:0] len;
    len = 16'd0;
    iq.push_back(info);
    for (int i = 0; i < nb; i++) begin
      d = {$urandom(), $urandom()};
      if (i == nb - 1) begin
        w   = {1'b1, last_keep, d};
        len = len + popcnt8(last_keep);
      end else begin
        w   = {1'b0, 8'hFF, d};
        len = len + 16'd8;
      end
      dq.push_back(w);
      if (info[0]) exp_q.push_back(w);
    end
    if (info[0]) len_q.push_back(len);
    update_heads();
  endtask

  // One clock cycle: sample at the falling edge, update FIFO models after
  // the rising edge. Called with time positioned just after a rising edge.
  task automatic tick();
    bit          pd, pi;
    logic [72:0] beat, e;
    logic [15:0] el;
    @(negedge s2mm_clk);
    cyc++;
    pd   = data_fifo_rden;
    pi   = info_fifo_rden;
    beat = {s2mm_tlast, s2mm_tkeep, s2mm_tdata};
    if (s2mm_tvalid) valid_cnt++;

    if (held) begin
      total++;
      if ({s2mm_tvalid, beat} !== {1'b1, held_val}) begin
        bad++;
        $display("FAIL axis_stable: got valid=%b beat=%h required valid=1 beat=%h", s2mm_tvalid, beat, held_val);
      end
    end

    if (s2mm_tvalid && !s2mm_tready) begin
      total++;
      if (data_fifo_rden !== 1'b0) begin
        bad++;
        $display("FAIL no_pop_when_full: got rden=%b required 0", data_fifo_rden);
      end
    end

    if (s2mm_tvalid && first_pending) begin
      total++;
      if (cyc != info_pop_cyc + 2) begin
        bad++;
        $display("FAIL first_valid_latency: got %0d cycles after info pop, required 2", cyc - info_pop_cyc);
      end
      if (gap_check && gap_armed) begin
        gap_checks++;
        total++;
        if (cyc != last_end_cyc + 3) begin
          bad++;
          $display("FAIL frame_gap: got first valid %0d cycles after frame end, required 3", cyc - last_end_cyc);
        end
      end
      first_pending = 0;
      gap_armed     = 0;
    end

    if (s2mm_tvalid && s2mm_tready) begin
      hs_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_beat: got beat=%h required none", beat);
      end else begin
        e = exp_q.pop_front();
        if (beat !== e) begin
          bad++;
          $display("FAIL beat_data: got %h required %h", beat, e);
        end
      end
      if (s2mm_tlast) begin
        last_end_cyc = cyc;
        gap_armed    = 1;
      end
    end

    if (frame_len_valid) begin
      len_pulses++;
      total++;
      if (len_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_len_pulse: got frame_len=%0d required no pulse", frame_len);
      end else begin
        el = len_q.pop_front();
        if (frame_len !== el) begin
          bad++;
          $display("FAIL frame_len_sb: got %0d required %0d", frame_len, el);
        end
      end
    end

    if (pi) begin
      info_pop_cyc  = cyc;
      cur_good      = info_fifo_rdata[0];
      first_pending = info_fifo_rdata[0];
    end
    if (pd) begin
      pop_cnt++;
      if (!cur_good && data_fifo_rdata[72]) begin
        last_end_cyc = cyc;
        gap_armed    = 1;
      end
    end

    held        = s2mm_tvalid & ~s2mm_tready;
    held_val    = beat;
    prev_tvalid = s2mm_tvalid;

    @(posedge s2mm_clk);
    if (pd && dq.size() > 0) void'(dq.pop_front());
    if (pi && iq.size() > 0) void'(iq.pop_front());
    #1;
    update_heads();
    rdy_idx++;
    s2mm_tready = (ready_mode == 0) ? 1'b1 : ((rdy_idx % 3) == 0);
  endtask

  task automatic run_until_done(input int maxc);
    int n;
    n = 0;
    while ((dq.size() != 0 || iq.size() != 0 || exp_q.size() != 0 || len_q.size() != 0) && n < maxc) begin
      tick();
      n++;
    end
    repeat (4) tick();
    total++;
    if (n >= maxc) begin
      bad++;
      $display("FAIL timeout: got %0d cycles without draining, required fewer than %0d", n, maxc);
    end
  endtask

  task automatic clear_counts();
    pop_cnt = 0; hs_cnt = 0; len_pulses = 0; valid_cnt = 0; gap_checks = 0;
  endtask

  task automatic test_reset();
    s2mm_resetn = 1'b1;
    s2mm_tready = 1'b1;
    update_heads();
    #1 s2mm_resetn = 1'b0;
    #20;
    total++;
    if ({s2mm_tvalid, s2mm_tlast, s2mm_tkeep, s2mm_tdata} !== 74'd0) begin
      bad++;
      $display("FAIL reset_axis: got valid=%b last=%b keep=%h data=%h required all 0", s2mm_tvalid, s2mm_tlast, s2mm_tkeep, s2mm_tdata);
    end
    total++;
    if ({data_fifo_rden, info_fifo_rden, frame_len_valid} !== 3'b000) begin
      bad++;
      $display("FAIL reset_strobes: got %b required 000", {data_fifo_rden, info_fifo_rden, frame_len_valid});
    end
    total++;
    if ({frame_len, good_frames, bad_frames, ifm_out_fsm_dbg} !== 84'd0) begin
      bad++;
      $display("FAIL reset_stats: got len=%0d good=%0d bad=%0d dbg=%0d required all 0", frame_len, good_frames, bad_frames, ifm_out_fsm_dbg);
    end
    @(negedge s2mm_clk);
    s2mm_resetn = 1'b1;
    @(posedge s2mm_clk);
    #1;
  endtask

  task automatic test_good3();
    clear_counts();
    push_frame(8'h01, 3, 8'h0F);
    run_until_done(50);
    total++;
    if (hs_cnt !== 3) begin bad++; $display("FAIL good3_beats: got %0d required 3", hs_cnt); end
    total++;
    if (frame_len !== 16'd20 || len_pulses !== 1) begin
      bad++; $display("FAIL good3_len: got len=%0d pulses=%0d required len=20 pulses=1", frame_len, len_pulses);
    end
    total++;
    if (good_frames !== 32'd1) begin bad++; $display("FAIL good3_count: got %0d required 1", good_frames); end
  endtask

  task automatic test_bad();
    clear_counts();
    push_frame(8'h00, 4, 8'hFF);
    run_until_done(50);
    total++;
    if (valid_cnt !== 0) begin bad++; $display("FAIL bad_no_valid: got %0d valid cycles required 0", valid_cnt); end
    total++;
    if (pop_cnt !== 4) begin bad++; $display("FAIL bad_pops: got %0d required 4", pop_cnt); end
    total++;
    if (bad_frames !== 32'd1) begin bad++; $display("FAIL bad_count: got %0d required 1", bad_frames); end
    total++;
    if (ifm_out_fsm_dbg !== 4'h0) begin bad++; $display("FAIL bad_idle: got dbg=%0d required 0", ifm_out_fsm_dbg); end
  endtask

  task automatic test_backpressure();
    logic [31:0] g0;
    g0 = good_frames;
    clear_counts();
    ready_mode = 1;
    push_frame(8'h01, 5, 8'h3C);
    run_until_done(100);
    ready_mode = 0;
    total++;
    if (hs_cnt !== 5) begin bad++; $display("FAIL bp_beats: got %0d required 5", hs_cnt); end
    total++;
    if (frame_len !== 16'd36) begin bad++; $display("FAIL bp_len: got %0d required 36", frame_len); end
    total++;
    if (good_frames - g0 !== 32'd1) begin bad++; $display("FAIL bp_count: got delta %0d required 1", good_frames - g0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] g0, b0;
    g0 = good_frames;
    b0 = bad_frames;
    clear_counts();
    gap_check = 1;
    gap_armed = 0;
    push_frame(8'hA5, 4, 8'hFF);
    push_frame(8'hFE, 3, 8'h01);
    push_frame(8'h01, 2, 8'h80);
    run_until_done(100);
    gap_check = 0;
    total++;
    if (hs_cnt !== 6 || len_pulses !== 2) begin
      bad++; $display("FAIL b2b_beats: got beats=%0d pulses=%0d required 6 and 2", hs_cnt, len_pulses);
    end
    total++;
    if (good_frames - g0 !== 32'd2 || bad_frames - b0 !== 32'd1) begin
      bad++; $display("FAIL b2b_counts: got good+%0d bad+%0d required good+2 bad+1", good_frames - g0, bad_frames - b0);
    end
    total++;
    if (gap_checks !== 1) begin bad++; $display("FAIL b2b_gap_seen: got %0d gap checks required 1", gap_checks); end
  endtask

  task automatic test_single_keep0();
    clear_counts();
    push_frame(8'h01, 1, 8'h01);
    run_until_done(50);
    total++;
    if (hs_cnt !== 1 || frame_len !== 16'd1) begin
      bad++; $display("FAIL single_beat: got beats=%0d len=%0d required 1 and 1", hs_cnt, frame_len);
    end
    clear_counts();
    push_frame(8'h01, 2, 8'h00);
    run_until_done(50);
    total++;
    if (hs_cnt !== 2 || frame_len !== 16'd8) begin
      bad++; $display("FAIL keep_zero: got beats=%0d len=%0d required 2 and 8", hs_cnt, frame_len);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_counts();
    push_frame(8'h01, 6, 8'hFF);
    n = 0;
    while (hs_cnt < 1 && n < 20) begin tick(); n++; end
    total++;
    if (hs_cnt < 1) begin bad++; $display("FAIL rst_mid_start: got %0d beats required 1", hs_cnt); end
    #2;
    s2mm_resetn = 1'b0;
    dq.delete(); iq.delete(); exp_q.delete(); len_q.delete();
    update_heads();
    #1;
    total++;
    if ({s2mm_tvalid, s2mm_tlast, s2mm_tkeep, s2mm_tdata} !== 74'd0) begin
      bad++; $display("FAIL rst_mid_axis: got valid=%b last=%b keep=%h data=%h required all 0", s2mm_tvalid, s2mm_tlast, s2mm_tkeep, s2mm_tdata);
    end
    total++;
    if ({data_fifo_rden, info_fifo_rden, frame_len_valid} !== 3'b000) begin
      bad++; $display("FAIL rst_mid_strobes: got %b required 000", {data_fifo_rden, info_fifo_rden, frame_len_valid});
    end
    total++;
    if ({frame_len, good_frames, bad_frames, ifm_out_fsm_dbg} !== 84'd0) begin
      bad++; $display("FAIL rst_mid_stats: got len=%0d good=%0d bad=%0d dbg=%0d required all 0", frame_len, good_frames, bad_frames, ifm_out_fsm_dbg);
    end
    held = 0; prev_tvalid = 0; first_pending = 0; gap_armed = 0; cur_good = 0;
    repeat (2) @(posedge s2mm_clk);
    @(negedge s2mm_clk);
    #2 s2mm_resetn = 1'b1;
    @(posedge s2mm_clk);
    #1;
    clear_counts();
    push_frame(8'h01, 3, 8'hFF);
    run_until_done(50);
    total++;
    if (hs_cnt !== 3 || frame_len !== 16'd24) begin
      bad++; $display("FAIL rst_mid_after: got beats=%0d len=%0d required 3 and 24", hs_cnt, frame_len);
    end
    total++;
    if (good_frames !== 32'd1) begin bad++; $display("FAIL rst_mid_count: got %0d required 1", good_frames); end
  endtask

  initial begin
    test_reset();
    test_good3();
    test_bad();
    test_backpressure();
    test_back_to_back();
    test_single_keep0();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifm_out_fsm.md
# ifm_out_fsm

Receive-path egress stage of the 10G Ethernet core. It pairs each frame's status byte from the info FIFO with that frame's beats in the data FIFO. Good frames are replayed onto the S2MM AXI-Stream toward the DMA engine. Errored frames are drained silently. Frame length and good/bad frame statistics are reported alongside.

## Interface
- Parameters: none.
- `s2mm_clk` in 1: clock, all logic on rising edge.
- `s2mm_resetn` in 1: reset, asynchronous, active-low. One clock, async active-low reset.
- `data_fifo_rdata` in 73: FWFT head word; [63:0] data, [71:64] keep, [72] last.
- `data_fifo_empty` in 1: data FIFO empty.
- `data_fifo_rden` out 1: pop data head this cycle.
- `info_fifo_rdata` in 8: FWFT head status; bit0 = 1 means frame good, [7:1] ignored.
- `info_fifo_empty` in 1: info FIFO empty.
- `info_fifo_rden` out 1: pop info head this cycle.
- `s2mm_tdata` out 64, `s2mm_tkeep` out 8, `s2mm_tlast` out 1, `s2mm_tvalid` out 1: registered AXI-Stream master.
- `s2mm_tready` in 1: downstream ready.
- `frame_len` out 16: byte length of the last forwarded good frame.
- `frame_len_valid` out 1: one-cycle pulse when `frame_len` updates.
- `good_frames` out 32, `bad_frames` out 32: wrapping frame counters.
- `ifm_out_fsm_dbg` out 4: {2'b00, state}.

## Operation
- States: S_IDLE=0, S_PASS=1, S_DROP=2; value 3 is unused and returns to S_IDLE.
- S_IDLE:
  - When `~info_fifo_empty`, assert `info_fifo_rden` for one cycle.
  - Go to S_PASS if `info_fifo_rdata[0]`, else S_DROP.
  - Data is never popped in S_IDLE.
- S_PASS:
  - Single output register (`s2mm_*`) with a `popped_last` flag, cleared on entry.
  - Load condition: `~popped_last & ~data_fifo_empty & (~s2mm_tvalid | s2mm_tready)`.
  - On load: `data_fifo_rden`=1, output regs take rdata fields, `s2mm_tvalid`<=1. If rdata[72]=1, set `popped_last`.
  - If `s2mm_tready` and no load, `s2mm_tvalid`<=0.
  - Exit to S_IDLE on `s2mm_tvalid & s2mm_tready & s2mm_tlast`.
- S_DROP:
  - `data_fifo_rden = ~data_fifo_empty`; `s2mm_tvalid` stays 0.
  - On popping a word with [72]=1, go to S_IDLE and increment `bad_frames`.
- Length, kept in a 16-bit accumulator cleared on S_PASS entry:
  - +8 per loaded non-last beat.
  - On the last beat, + popcount(keep); keep=0 adds 0.
  - Accumulator saturates at 16'hFFFF.
  - On the last-beat handshake: `frame_len` <= accumulator total, pulse `frame_len_valid`, increment `good_frames`.
- Counters wrap 32'hFFFFFFFF -> 0.

## Timing
- Reset values:
  - State S_IDLE; `popped_last`=0.
  - `s2mm_tvalid`=0, `s2mm_tlast`=0, `s2mm_tdata`=0, `s2mm_tkeep`=0.
  - `data_fifo_rden`=0, `info_fifo_rden`=0.
  - `frame_len`=0, `frame_len_valid`=0, both counters 0.
  - Debug output 0.
- `data_fifo_rden` and `info_fifo_rden` are combinational from state, flags and FIFO flags. All other outputs are registered.
- Latency: info non-empty at cycle N -> info pop at N -> state S_PASS at N+1 -> first data pop at N+1 -> `s2mm_tvalid` at N+2.
- Full throughput: one beat per cycle while `s2mm_tready`=1 and data is available.
- Bubble between frames: last handshake at M -> S_IDLE at M+1 -> next info pop at M+1 -> next first beat valid at M+3.
- AXIS rules:
  - While `s2mm_tvalid & ~s2mm_tready`, all `s2mm_*` stay stable.
  - `tvalid` never drops without a handshake.
- Data FIFO empty mid-frame in S_PASS or S_DROP: stall with no pop. Output holds or drains; resume when non-empty.
- The info FIFO is never popped outside S_IDLE, even when it is non-empty.
- Drop rate: one word per cycle, independent of `s2mm_tready`.
- Reset mid-frame:
  - Immediate return to reset values.
  - The partial frame is not completed.
  - The FIFOs share `s2mm_resetn` and flush with this block.

## Test plan
- Good 3-beat frame:
  - Stimulus: info 8'h01; data beats D0, D1 with keep FF, D2 with keep 0F and last.
  - Required: three AXIS beats, identical data, tlast on D2.
  - Required: `frame_len`=20, one `frame_len_valid` pulse, `good_frames`=1.
- Bad frame:
  - Stimulus: info 8'h00; 4 beats, last beat keep FF.
  - Required: `s2mm_tvalid` never asserts, 4 data pops, `bad_frames`=1, back in S_IDLE.
- Backpressure:
  - Stimulus: good 5-beat frame with `s2mm_tready` toggling 1,0,0,1...
  - Required: each beat held stable while tready=0; order and count are exact; no pop while the output register is full and tready=0.
- Back-to-back frames:
  - Stimulus: good, bad, good frames queued, tready=1.
  - Required: only the two good frames appear; counters good=2, bad=1; 2-cycle gap before each new frame's first valid.
- Single-beat and keep-zero frames:
  - Stimulus: good frame of one beat with keep 8'h01 and last.
  - Required: one beat with tlast, `frame_len`=1.
  - Stimulus: good frame whose last beat has keep 0 after 2 beats.
  - Required: `frame_len`=8.
- Reset mid-frame:
  - Stimulus: assert `s2mm_resetn`=0 asynchronously during beat 2 of a 6-beat good frame.
  - Required: all outputs at reset values immediately; after release, the next queued frame is forwarded correctly.
